seg_scan_driver: RTL

Parametrised multiplexed seven-segment display driver: latches a packed hex value, scans it across `DIGITS` common-pin digits at a programmable refresh rate, and drives segment and digit-select pins with configurable polarity. It supersedes the single-digit combinational hex decoder in the display path. It adds tear-free frame updates, leading-zero blanking, decimal points and a frame strobe. It sits between the system registers and the board display pins.

---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_driver.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path: hex-to-segment table,
// pin polarity helper and the segment bus width.
package seg_pkg;

    // Segment bus width: bits [6:0] are segments a..g, bit [7] is the decimal point
    localparam int SEG_W = 8;

    // Hex-to-segment table; element n holds the a..g pattern for hex digit n
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Pin levels of a fully dark segment bus for each polarity
    localparam logic [SEG_W-1:0] SEG_OFF_ACTIVE_HIGH = '0;
    localparam logic [SEG_W-1:0] SEG_OFF_ACTIVE_LOW  = '1;

    // Level a single pin sits at when it is inactive, for a given polarity
    function automatic logic inactive_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to a..g segment decoder built from the shared table.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment driver: double-buffered value, digit scanning,
// leading-zero blanking, decimal points, frame strobe and pin polarity.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter bit ACTIVE_LOW_SEG = 1'b0,
    parameter bit ACTIVE_LOW_AN  = 1'b0
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [SEG_W-1:0]      seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [SEG_W-1:0]  SEG_OFF  = ACTIVE_LOW_SEG ? SEG_OFF_ACTIVE_LOW : SEG_OFF_ACTIVE_HIGH;
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{inactive_level(ACTIVE_LOW_AN)}};

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                tick;
    logic                wrap;
    logic [4*DIGITS-1:0] pend_val;
    logic [DIGITS-1:0]   pend_dp;
    logic [4*DIGITS-1:0] disp_val;
    logic [DIGITS-1:0]   disp_dp;
    logic [DIGITS-1:0]   blank_mask;
    logic                zero_run;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic [6:0]          cur_segs;
    logic [DIGITS-1:0]   an_next;
    logic [SEG_W-1:0]    seg_next;

    // A tick ends the current digit slot; the tick on the last digit ends the frame
    assign tick = enable && (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Per-digit dwell divider; frozen while the display is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

    // Digit index advances once per dwell period and wraps at the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (tick) begin
            idx <= wrap ? '0 : idx + IDX_W'(1);
        end
    end

    // Frame strobe lands together with the index returning to digit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
        end
    end

    // Pending buffer accepts new data at any time, even when disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val <= '0;
            pend_dp  <= '0;
        end else if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
        end
    end

    // Displayed buffer only changes between frames; a load on the boundary bypasses pend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_val <= '0;
            disp_dp  <= '0;
        end else if (wrap) begin
            disp_val <= load ? value : pend_val;
            disp_dp  <= load ? dp_in : pend_dp;
        end
    end

    // Digit i>0 is blanked while it and every digit to its left hold zero
    always_comb begin
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run      = zero_run && (disp_val[4*i +: 4] == 4'h0);
            blank_mask[i] = blank_lz && zero_run;
        end
    end

    // Select the nibble, decimal point and blank flag of the digit being scanned
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = disp_val[4*i +: 4];
                cur_dp    = disp_dp[i];
                cur_blank = blank_mask[i];
            end
        end
    end

    seg_hex_decode u_decode (
        .nibble (cur_nib),
        .segs   (cur_segs)
    );

    // Logical pin values before polarity; everything dark while disabled
    always_comb begin
        an_next  = '0;
        seg_next = '0;
        if (enable) begin
            an_next  = DIGITS'(1) << idx;
            seg_next = {cur_dp, cur_blank ? 7'h00 : cur_segs};
        end
    end

    // Output registers hold pin-level values so reset drives the inactive polarity directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= an_next ^ AN_OFF;
            seg <= seg_next ^ SEG_OFF;
        end
    end

endmodule
